// File: rtl/gmii_tx_sched_pkg.sv
// Shared definitions for the GMII transmit scheduler: source indices,
// FSM state encoding and a counter-width helper.
package gmii_tx_sched_pkg;

    localparam logic [1:0] SRC_ARP  = 2'd0;
    localparam logic [1:0] SRC_ICMP = 2'd1;
    localparam logic [1:0] SRC_UDP  = 2'd2;
    localparam logic [1:0] SRC_NONE = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_XFER  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_IFG   = 3'd4
    } state_e;

    // Bits needed for a counter holding 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tx_arb_pick.sv
// Winner selection for the scheduler: fixed priority ARP > ICMP > UDP,
// overridden in favour of UDP once it has been passed over STARVE_LIMIT times.
module tx_arb_pick
    import gmii_tx_sched_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [2:0] i_req,
    input  logic       i_take,
    output logic [1:0] o_win,
    output logic [2:0] o_win_oh
);

    localparam int              CW    = cnt_w(STARVE_LIMIT + 1);
    localparam logic [CW-1:0]   LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_q, starve_d;

    // Combinational winner; starvation override checked before fixed priority.
    always_comb begin
        o_win = SRC_NONE;
        if (i_req[SRC_UDP] && (starve_q == LIMIT)) begin
            o_win = SRC_UDP;
        end else if (i_req[SRC_ARP]) begin
            o_win = SRC_ARP;
        end else if (i_req[SRC_ICMP]) begin
            o_win = SRC_ICMP;
        end else if (i_req[SRC_UDP]) begin
            o_win = SRC_UDP;
        end
    end

    // One-hot view of the winner.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_oh
            assign o_win_oh[gi] = (o_win == 2'(gi));
        end
    endgenerate

    // Starvation count: advances when ARP/ICMP win over a waiting UDP, saturates.
    always_comb begin
        starve_d = starve_q;
        if (i_take) begin
            if ((o_win == SRC_UDP) || !i_req[SRC_UDP]) begin
                starve_d = '0;
            end else if (starve_q != LIMIT) begin
                starve_d = starve_q + CW'(1);
            end
        end
    end

    // Starvation counter register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/gmii_tx_sched.sv
// GMII transmit scheduler: arbitrates three frame sources onto one GMII
// transmit port, enforcing start timeout, maximum frame length and IFG.
module gmii_tx_sched
    import gmii_tx_sched_pkg::*;
#(
    parameter int IFG_CYCLES    = 12,
    parameter int START_TIMEOUT = 64,
    parameter int MAX_FRAME     = 1526,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic        i_gmii_clk,
    input  logic        i_sys_rst,
    input  logic [2:0]  i_req,
    output logic [2:0]  o_gnt,
    input  logic [2:0]  i_dv,
    input  logic [23:0] i_data,
    output logic [1:0]  o_owner,
    output logic        o_busy,
    output logic        o_gmii_tx_en,
    output logic        o_gmii_tx_er,
    output logic [7:0]  o_gmii_tx_data,
    output logic        o_timeout,
    output logic        o_overlen
);

    localparam int SW = cnt_w(START_TIMEOUT);
    localparam int BW = cnt_w(MAX_FRAME + 1);
    localparam int IW = cnt_w(IFG_CYCLES);

    localparam logic [SW-1:0] START_LAST = SW'((START_TIMEOUT > 0) ? START_TIMEOUT - 1 : 0);
    localparam logic [BW-1:0] BYTE_MAX   = BW'(MAX_FRAME);
    localparam logic [IW-1:0] IFG_LAST   = IW'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

    state_e        state_q, state_d;
    logic [1:0]    owner_q, owner_d;
    logic [2:0]    gnt_q, gnt_d;
    logic [SW-1:0] start_q, start_d;
    logic [BW-1:0] byte_q, byte_d;
    logic [IW-1:0] ifg_q, ifg_d;
    logic          tx_en_q, tx_en_d;
    logic          tx_er_q, tx_er_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          timeout_q, timeout_d;
    logic          overlen_q, overlen_d;

    logic          take;
    logic [1:0]    win;
    logic [2:0]    win_oh;
    logic          owner_dv;
    logic [7:0]    owner_byte;
    logic [7:0]    src_byte [3];

    // Split the packed data bus into one byte per source.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_src
            assign src_byte[gi] = i_data[8*gi +: 8];
        end
    endgenerate

    tx_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .i_clk    (i_gmii_clk),
        .i_rst    (i_sys_rst),
        .i_req    (i_req),
        .i_take   (take),
        .o_win    (win),
        .o_win_oh (win_oh)
    );

    // Select the current owner's lane; non-owners are never looked at.
    always_comb begin
        owner_dv   = 1'b0;
        owner_byte = 8'h00;
        case (owner_q)
            SRC_ARP:  begin owner_dv = i_dv[0]; owner_byte = src_byte[0]; end
            SRC_ICMP: begin owner_dv = i_dv[1]; owner_byte = src_byte[1]; end
            SRC_UDP:  begin owner_dv = i_dv[2]; owner_byte = src_byte[2]; end
            default:  ;
        endcase
    end

    // Next-state and registered-output logic for the scheduler FSM.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        gnt_d     = 3'b000;
        start_d   = start_q;
        byte_d    = byte_q;
        ifg_d     = ifg_q;
        tx_en_d   = 1'b0;
        tx_er_d   = 1'b0;
        tx_data_d = 8'h00;
        timeout_d = 1'b0;
        overlen_d = 1'b0;
        take      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|i_req) begin
                    take    = 1'b1;
                    gnt_d   = win_oh;
                    owner_d = win;
                    start_d = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (owner_dv) begin
                    tx_en_d   = 1'b1;
                    tx_data_d = owner_byte;
                    byte_d    = BW'(1);
                    state_d   = ST_XFER;
                end else if (start_q == START_LAST) begin
                    timeout_d = 1'b1;
                    owner_d   = SRC_NONE;
                    start_d   = '0;
                    state_d   = ST_IDLE;
                end else begin
                    start_d = start_q + SW'(1);
                end
            end
            ST_XFER: begin
                if (owner_dv) begin
                    tx_en_d   = 1'b1;
                    tx_data_d = owner_byte;
                    if (byte_q == BYTE_MAX) begin
                        // Frame too long: mark the extra byte as errored and stop.
                        tx_er_d   = 1'b1;
                        overlen_d = 1'b1;
                        state_d   = ST_DRAIN;
                    end else begin
                        byte_d = byte_q + BW'(1);
                    end
                end else begin
                    ifg_d   = '0;
                    state_d = ST_IFG;
                end
            end
            ST_DRAIN: begin
                if (!owner_dv) begin
                    ifg_d   = '0;
                    state_d = ST_IFG;
                end
            end
            ST_IFG: begin
                if (ifg_q == IFG_LAST) begin
                    ifg_d   = '0;
                    owner_d = SRC_NONE;
                    state_d = ST_IDLE;
                end else begin
                    ifg_d = ifg_q + IW'(1);
                end
            end
            default: begin
                owner_d = SRC_NONE;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any frame in flight.
    always_ff @(posedge i_gmii_clk) begin
        if (i_sys_rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= SRC_NONE;
            gnt_q     <= 3'b000;
            start_q   <= '0;
            byte_q    <= '0;
            ifg_q     <= '0;
            tx_en_q   <= 1'b0;
            tx_er_q   <= 1'b0;
            tx_data_q <= 8'h00;
            timeout_q <= 1'b0;
            overlen_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            gnt_q     <= gnt_d;
            start_q   <= start_d;
            byte_q    <= byte_d;
            ifg_q     <= ifg_d;
            tx_en_q   <= tx_en_d;
            tx_er_q   <= tx_er_d;
            tx_data_q <= tx_data_d;
            timeout_q <= timeout_d;
            overlen_q <= overlen_d;
        end
    end

    assign o_gnt          = gnt_q;
    assign o_owner        = owner_q;
    assign o_busy         = (state_q != ST_IDLE);
    assign o_gmii_tx_en   = tx_en_q;
    assign o_gmii_tx_er   = tx_er_q;
    assign o_gmii_tx_data = tx_data_q;
    assign o_timeout      = timeout_q;
    assign o_overlen      = overlen_q;

endmodule

// File: tb/tb_gmii_tx_sched.sv
// Directed bench for gmii_tx_sched with default parameters.
module tb_gmii_tx_sched;

    logic        clk = 1'b0;
    logic        srst = 1'b1;
    logic [2:0]  req = 3'b000;
    logic [2:0]  dv = 3'b000;
    logic [23:0] data = 24'h0;

    logic [2:0]  o_gnt;
    logic [1:0]  o_owner;
    logic        o_busy;
    logic        o_gmii_tx_en;
    logic        o_gmii_tx_er;
    logic [7:0]  o_gmii_tx_data;
    logic        o_timeout;
    logic        o_overlen;

    int n_pass = 0;
    int n_chk  = 0;
    int bad, en_cnt, er_cnt, ov_cnt, to_cnt;
    logic [2:0] g;

    gmii_tx_sched dut (
        .i_gmii_clk     (clk),
        .i_sys_rst      (srst),
        .i_req          (req),
        .o_gnt          (o_gnt),
        .i_dv           (dv),
        .i_data         (data),
        .o_owner        (o_owner),
        .o_busy         (o_busy),
        .o_gmii_tx_en   (o_gmii_tx_en),
        .o_gmii_tx_er   (o_gmii_tx_er),
        .o_gmii_tx_data (o_gmii_tx_data),
        .o_timeout      (o_timeout),
        .o_overlen      (o_overlen)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Step until a grant pulse appears, giving up after a fixed budget.
    task automatic wait_gnt(output logic [2:0] gv);
        gv = 3'b000;
        for (int k = 0; k < 200; k++) begin
            step();
            if (o_gnt !== 3'b000) begin
                gv = o_gnt;
                break;
            end
        end
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_gnt", 32'(o_gnt), 32'h0);
        chk("rst_owner", 32'(o_owner), 32'h3);
        chk("rst_busy", 32'(o_busy), 32'h0);
        chk("rst_tx", {o_gmii_tx_en, o_gmii_tx_er, o_gmii_tx_data}, 32'h0);
        chk("rst_pulses", {o_timeout, o_overlen}, 32'h0);
        srst = 1'b0;
        step();

        // ARP and UDP together: ARP first, UDP after frame + 12 IFG cycles
        req = 3'b101;
        step();
        chk("arp_udp_gnt", 32'(o_gnt), 32'h1);
        chk("arp_owner", 32'(o_owner), 32'h0);
        chk("arp_busy", 32'(o_busy), 32'h1);
        req = 3'b100;
        bad = 0;
        en_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            dv = 3'b001;
            data = {16'h0, 8'(8'h10 + i)};
            step();
            if (o_gmii_tx_en !== 1'b1 || o_gmii_tx_data !== 8'(8'h10 + i)) bad++;
        end
        chk("arp_bytes", 32'(bad), 32'h0);
        dv = 3'b000;
        data = 24'h0;
        step();
        chk("arp_end_en", 32'(o_gmii_tx_en), 32'h0);
        for (int i = 0; i < 12; i++) begin
            step();
            if (o_gnt !== 3'b000 || o_gmii_tx_en !== 1'b0) en_cnt++;
        end
        chk("ifg_quiet", 32'(en_cnt), 32'h0);
        chk("ifg_idle_owner", 32'(o_owner), 32'h3);
        chk("ifg_idle_busy", 32'(o_busy), 32'h0);
        step();
        chk("udp_after_ifg_gnt", 32'(o_gnt), 32'h4);
        chk("udp_owner", 32'(o_owner), 32'h2);

        // UDP 60-byte frame while ARP lane toggles
        req = 3'b000;
        en_cnt = 0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            en_cnt += int'(o_gmii_tx_en);
        end
        for (int i = 0; i < 60; i++) begin
            dv = {1'b1, 1'b0, 1'(i)};
            data = {8'(i * 3 + 7), 8'h00, 8'(i * 5)};
            step();
            if (o_gmii_tx_en !== 1'b1 || o_gmii_tx_data !== 8'(i * 3 + 7)) bad++;
            en_cnt += int'(o_gmii_tx_en);
        end
        for (int i = 0; i < 13; i++) begin
            dv = {2'b00, 1'(i)};
            data = {16'h0, 8'(i)};
            step();
            en_cnt += int'(o_gmii_tx_en);
        end
        dv = 3'b000;
        data = 24'h0;
        chk("udp60_bytes", 32'(bad), 32'h0);
        chk("udp60_en_count", 32'(en_cnt), 32'd60);
        chk("udp60_idle_busy", 32'(o_busy), 32'h0);
        chk("udp60_idle_owner", 32'(o_owner), 32'h3);

        // ICMP start timeout with UDP pending
        req = 3'b010;
        step();
        chk("icmp_gnt", 32'(o_gnt), 32'h2);
        chk("icmp_owner", 32'(o_owner), 32'h1);
        req = 3'b100;
        to_cnt = 0;
        for (int k = 1; k < 64; k++) begin
            dv = {2'b00, 1'(k)};
            step();
            to_cnt += int'(o_timeout);
        end
        chk("timeout_early", 32'(to_cnt), 32'h0);
        chk("timeout_wait_busy", 32'(o_busy), 32'h1);
        dv = 3'b000;
        step();
        chk("timeout_pulse", 32'(o_timeout), 32'h1);
        chk("timeout_owner", 32'(o_owner), 32'h3);
        chk("timeout_busy", 32'(o_busy), 32'h0);
        step();
        chk("timeout_once", 32'(o_timeout), 32'h0);
        chk("pending_udp_gnt", 32'(o_gnt), 32'h4);
        chk("pending_udp_owner", 32'(o_owner), 32'h2);

        // UDP over-length frame: dv held 1600 cycles
        req = 3'b000;
        bad = 0;
        en_cnt = 0;
        er_cnt = 0;
        ov_cnt = 0;
        for (int i = 0; i < 1600; i++) begin
            dv = 3'b100;
            data = {8'(i), 16'h0};
            step();
            en_cnt += int'(o_gmii_tx_en);
            er_cnt += int'(o_gmii_tx_er);
            ov_cnt += int'(o_overlen);
            if (i <= 1525) begin
                if (o_gmii_tx_en !== 1'b1 || o_gmii_tx_er !== 1'b0 || o_gmii_tx_data !== 8'(i)) bad++;
            end else if (i == 1526) begin
                if (o_gmii_tx_en !== 1'b1 || o_gmii_tx_er !== 1'b1 || o_overlen !== 1'b1) bad++;
            end else begin
                if (o_gmii_tx_en !== 1'b0 || o_gmii_tx_er !== 1'b0 || o_gmii_tx_data !== 8'h00) bad++;
            end
        end
        chk("ovl_cycles", 32'(bad), 32'h0);
        chk("ovl_en_count", 32'(en_cnt), 32'd1527);
        chk("ovl_er_count", 32'(er_cnt), 32'd1);
        chk("ovl_pulse_count", 32'(ov_cnt), 32'd1);
        chk("ovl_drain_busy", 32'(o_busy), 32'h1);
        dv = 3'b000;
        data = 24'h0;
        for (int i = 0; i < 12; i++) step();
        chk("ovl_ifg_busy", 32'(o_busy), 32'h1);
        step();
        chk("ovl_idle_busy", 32'(o_busy), 32'h0);

        // Starvation: ARP continuous, UDP wins the 5th arbitration
        req = 3'b101;
        for (int n = 1; n <= 5; n++) begin
            wait_gnt(g);
            chk($sformatf("starve_arb%0d", n), 32'(g), (n == 5) ? 32'h4 : 32'h1);
            if (n < 5) begin
                dv = g;
                step();
                dv = 3'b000;
                step();
            end else begin
                req = 3'b000;
            end
        end

        // Reset at byte 30 of a UDP frame
        for (int i = 0; i < 30; i++) begin
            dv = 3'b100;
            data = {8'(8'hA0 + i), 16'h0};
            step();
        end
        chk("pre_rst_en", 32'(o_gmii_tx_en), 32'h1);
        srst = 1'b1;
        step();
        chk("midrst_tx", {o_gmii_tx_en, o_gmii_tx_er, o_gmii_tx_data}, 32'h0);
        chk("midrst_owner", 32'(o_owner), 32'h3);
        chk("midrst_busy_gnt", {o_busy, o_gnt}, 32'h0);
        srst = 1'b0;
        en_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            en_cnt += int'(o_gmii_tx_en);
        end
        chk("no_resume", 32'(en_cnt), 32'h0);
        dv = 3'b000;
        req = 3'b010;
        step();
        chk("post_rst_gnt", 32'(o_gnt), 32'h2);
        chk("post_rst_owner", 32'(o_owner), 32'h1);
        req = 3'b000;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
